// File: rtl/execute_cycle.sv
// ----------------------------------------------------------------------------
// execute_cycle -- execute stage of a 5-stage RISC-V pipeline.
//
// Takes the ID/EX pipeline register and does the following:
//   - selects operands through the forwarding muxes,
//   - runs the ALU,
//   - resolves branches and jumps,
//   - registers the results into EX/MEM.
//
// Ports
//   clk, rst            pipeline clock; synchronous active-high reset
//   RD1E, RD2E          register-file operands from ID/EX
//   PCE, ImmExtE        PC and sign-extended immediate of the instruction
//   PCPlus4E            PC+4 of the instruction
//   RdE                 destination register index
//   RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE   control bits
//   ResultWSrcE         result select (00 ALU, 01 memory, 10 PC+4)
//   ALUControlE         ALU operation select
//   ForwardAE/BE        operand select (00 RD, 01 ResultW, 10 ALUResultM)
//   ResultW             writeback-stage result for forwarding
//   PCSrcE, PCTargetE   combinational redirect request and target to fetch
//   *M outputs          EX/MEM pipeline register
// ----------------------------------------------------------------------------
module execute_cycle #(
   parameter int XLEN = 32,
   parameter int REGW = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] RD1E,
   input  logic [XLEN-1:0] RD2E,
   input  logic [XLEN-1:0] PCE,
   input  logic [XLEN-1:0] ImmExtE,
   input  logic [XLEN-1:0] PCPlus4E,
   input  logic [REGW-1:0] RdE,
   input  logic            RegWriteE,
   input  logic            MemWriteE,
   input  logic            BranchE,
   input  logic            JumpE,
   input  logic            ALUSrcE,
   input  logic [1:0]      ResultWSrcE,
   input  logic [2:0]      ALUControlE,
   input  logic [1:0]      ForwardAE,
   input  logic [1:0]      ForwardBE,
   input  logic [XLEN-1:0] ResultW,
   output logic            PCSrcE,
   output logic [XLEN-1:0] PCTargetE,
   output logic [XLEN-1:0] ALUResultM,
   output logic [XLEN-1:0] WriteDataM,
   output logic [XLEN-1:0] PCPlus4M,
   output logic [REGW-1:0] RdM,
   output logic            RegWriteM,
   output logic            MemWriteM,
   output logic [1:0]      ResultWSrcM
);

   logic [XLEN-1:0] src_a;
   logic [XLEN-1:0] write_data;
   logic [XLEN-1:0] src_b;
   logic [XLEN-1:0] alu_result;
   logic            zero;

   // Forwarding muxes. ALUResultM is the registered result of the previous
   // instruction, so a back-to-back dependence resolves without a stall.
   // The unused code 11 falls back to the register-file value.
   always_comb begin
      case (ForwardAE)
         2'b01:   src_a = ResultW;
         2'b10:   src_a = ALUResultM;
         default: src_a = RD1E;
      endcase
   end

   always_comb begin
      case (ForwardBE)
         2'b01:   write_data = ResultW;
         2'b10:   write_data = ALUResultM;
         default: write_data = RD2E;
      endcase
   end

   assign src_b = ALUSrcE ? ImmExtE : write_data;

   // ALU. Add and sub wrap; slt compares as two's-complement signed values.
   always_comb begin
      case (ALUControlE)
         3'b000:  alu_result = src_a + src_b;
         3'b001:  alu_result = src_a - src_b;
         3'b010:  alu_result = src_a & src_b;
         3'b011:  alu_result = src_a | src_b;
         3'b101:  alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
         default: alu_result = '0;
      endcase
   end

   assign zero = (alu_result == '0);

   // Branch and jump resolution. This path is deliberately not gated by rst.
   // While the upstream stages are in reset they present a zero bubble, and
   // that bubble already yields PCSrcE = 0.
   assign PCTargetE = PCE + ImmExtE;
   assign PCSrcE    = JumpE | (BranchE & zero);

   // EX/MEM pipeline register. It captures on every edge, because this stage
   // has no stall input.
   always_ff @(posedge clk) begin
      if (rst) begin
         ALUResultM  <= '0;
         WriteDataM  <= '0;
         PCPlus4M    <= '0;
         RdM         <= '0;
         RegWriteM   <= 1'b0;
         MemWriteM   <= 1'b0;
         ResultWSrcM <= 2'b00;
      end else begin
         ALUResultM  <= alu_result;
         WriteDataM  <= write_data;
         PCPlus4M    <= PCPlus4E;
         RdM         <= RdE;
         RegWriteM   <= RegWriteE;
         MemWriteM   <= MemWriteE;
         ResultWSrcM <= ResultWSrcE;
      end
   end

endmodule

// File: tb/tb_execute_cycle.sv
// ----------------------------------------------------------------------------
// tb_execute_cycle -- scoreboard bench for execute_cycle.
//
// The stimulus process drives one ID/EX bundle per cycle. For each bundle it
// checks the combinational redirect outputs and pushes the expected EX/MEM
// contents into a queue. A separate monitor pops that queue after each edge
// and compares the entry against the M outputs.
// ----------------------------------------------------------------------------
module tb_execute_cycle;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] RD1E = '0, RD2E = '0, PCE = '0, ImmExtE = '0, PCPlus4E = '0, ResultW = '0;
   logic [4:0]  RdE = '0;
   logic        RegWriteE = 1'b0, MemWriteE = 1'b0, BranchE = 1'b0, JumpE = 1'b0, ALUSrcE = 1'b0;
   logic [1:0]  ResultWSrcE = '0, ForwardAE = '0, ForwardBE = '0;
   logic [2:0]  ALUControlE = '0;
   logic        PCSrcE;
   logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
   logic [4:0]  RdM;
   logic        RegWriteM, MemWriteM;
   logic [1:0]  ResultWSrcM;

   execute_cycle #(.XLEN(32), .REGW(5)) dut (
      .clk(clk), .rst(rst),
      .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .ImmExtE(ImmExtE), .PCPlus4E(PCPlus4E),
      .RdE(RdE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE),
      .JumpE(JumpE), .ALUSrcE(ALUSrcE), .ResultWSrcE(ResultWSrcE),
      .ALUControlE(ALUControlE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .ResultW(ResultW), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
      .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
      .RdM(RdM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultWSrcM(ResultWSrcM)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] rd1, rd2, pc, imm, pc4, resw;
      logic [4:0]  rd;
      logic        regw, memw, br, jmp, alusrc;
      logic [1:0]  rws;
      logic [2:0]  aluc;
      logic [1:0]  fa, fb;
   } stim_t;

   typedef struct packed {
      logic [31:0] alu, wd, pc4;
      logic [4:0]  rd;
      logic        regw, memw;
      logic [1:0]  rws;
   } exp_t;

   exp_t        sb_q[$];
   int          total = 0;
   int          bad = 0;
   int          txn = 0;
   logic [31:0] model_alu_m = '0;   // the model's view of ALUResultM

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
      end
   endtask

   function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] rf,
                                           input logic [31:0] w, input logic [31:0] m);
      if (sel == 2'b01) return w;
      if (sel == 2'b10) return m;
      return rf;
   endfunction

   task automatic apply(input stim_t s, input bit r);
      logic [31:0] a, wd, b, res;
      exp_t        e;
      @(posedge clk);
      #2;
      rst = r;
      RD1E = s.rd1; RD2E = s.rd2; PCE = s.pc; ImmExtE = s.imm; PCPlus4E = s.pc4;
      ResultW = s.resw; RdE = s.rd; RegWriteE = s.regw; MemWriteE = s.memw;
      BranchE = s.br; JumpE = s.jmp; ALUSrcE = s.alusrc; ResultWSrcE = s.rws;
      ALUControlE = s.aluc; ForwardAE = s.fa; ForwardBE = s.fb;
      a   = ref_fwd(s.fa, s.rd1, s.resw, model_alu_m);
      wd  = ref_fwd(s.fb, s.rd2, s.resw, model_alu_m);
      b   = s.alusrc ? s.imm : wd;
      res = ref_alu(s.aluc, a, b);
      #1;
      chk("pcsrc", {31'd0, PCSrcE}, {31'd0, s.jmp | (s.br & (res == 32'd0))});
      chk("pctarget", PCTargetE, s.pc + s.imm);
      if (r) begin
         e = '0;
         model_alu_m = 32'd0;
      end else begin
         e.alu = res; e.wd = wd; e.pc4 = s.pc4; e.rd = s.rd;
         e.regw = s.regw; e.memw = s.memw; e.rws = s.rws;
         model_alu_m = res;
      end
      sb_q.push_back(e);
   endtask

   // Monitor: each edge delivers exactly one EX/MEM word.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            txn++;
            chk("alu_result_m", ALUResultM, e.alu);
            chk("write_data_m", WriteDataM, e.wd);
            chk("pc_plus4_m", PCPlus4M, e.pc4);
            chk("rd_m", {27'd0, RdM}, {27'd0, e.rd});
            chk("ctrl_m", {27'd0, RegWriteM, MemWriteM, ResultWSrcM, 1'b0},
                          {27'd0, e.regw, e.memw, e.rws, 1'b0});
            $display("txn %0d: alu=%h wd=%h pc4=%h rd=%0d rw=%b mw=%b src=%b",
                     txn, ALUResultM, WriteDataM, PCPlus4M, RdM, RegWriteM, MemWriteM, ResultWSrcM);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      stim_t s;
      // Reset held for two edges while the E inputs are nonzero.
      s = '0; s.rd1 = 3; s.rd2 = 4; s.rd = 5; s.regw = 1; s.memw = 1; s.rws = 2'b10; s.pc4 = 32'h8;
      apply(s, 1); apply(s, 1);
      // Release: add 3+4 into x5.
      s = '0; s.rd1 = 3; s.rd2 = 4; s.rd = 5; s.regw = 1;
      apply(s, 0);
      // Forwarding chain.
      s = '0; s.rd1 = 10; s.rd2 = 20; s.regw = 1;
      apply(s, 0);
      s = '0; s.fa = 2'b10; s.imm = 1; s.alusrc = 1;
      apply(s, 0);
      s = '0; s.fb = 2'b01; s.resw = 9; s.memw = 1; s.rd2 = 32'h77;
      apply(s, 0);
      // Branch taken, then not taken.
      s = '0; s.br = 1; s.aluc = 3'd1; s.rd1 = 32'h55; s.rd2 = 32'h55; s.pc = 32'h100; s.imm = 32'hFFFF_FFF0;
      apply(s, 0);
      s.rd2 = 32'h56;
      apply(s, 0);
      // Jump.
      s = '0; s.jmp = 1; s.rws = 2'b10; s.pc = 32'h40; s.pc4 = 32'h44; s.imm = 32'h20; s.regw = 1; s.rd = 1;
      apply(s, 0);
      // ALU edges. BranchE is set so that ZeroE can be seen on PCSrcE.
      s = '0; s.aluc = 3'd5; s.rd1 = 32'hFFFF_FFFF; s.rd2 = 1; s.br = 1;
      apply(s, 0);
      s.rd1 = 1; s.rd2 = 32'hFFFF_FFFF;
      apply(s, 0);
      s = '0; s.aluc = 3'd0; s.rd1 = 32'hFFFF_FFFF; s.rd2 = 1; s.br = 1;
      apply(s, 0);
      s = '0; s.aluc = 3'd7; s.rd1 = 32'h1234; s.rd2 = 32'h5678; s.br = 1;
      apply(s, 0);
      s = '0; s.fa = 2'b11; s.fb = 2'b11; s.rd1 = 32'h1234; s.rd2 = 32'h10; s.resw = 32'hDEAD; s.memw = 1;
      apply(s, 0);
      // Reset in the middle of a store stream.
      s = '0; s.memw = 1; s.rd1 = 32'h100; s.rd2 = 32'hAB;
      apply(s, 0); apply(s, 1); apply(s, 0); apply(s, 0);
      // Randomized traffic.
      for (int i = 0; i < 300; i++) begin
         s.rd1    = $urandom;
         s.rd2    = ($urandom_range(0, 3) == 0) ? s.rd1 : $urandom;
         s.pc     = $urandom;
         s.imm    = $urandom;
         s.pc4    = s.pc + 32'd4;
         s.resw   = $urandom;
         s.rd     = 5'($urandom);
         s.regw   = 1'($urandom);
         s.memw   = 1'($urandom);
         s.br     = 1'($urandom);
         s.jmp    = ($urandom_range(0, 7) == 0);
         s.alusrc = ($urandom_range(0, 3) == 0);
         s.rws    = 2'($urandom);
         s.aluc   = 3'($urandom);
         s.fa     = 2'($urandom);
         s.fb     = 2'($urandom);
         apply(s, $urandom_range(0, 19) == 0);
      end
      repeat (3) @(posedge clk);
      #2;
      chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/execute_cycle.md
Name: execute_cycle

Overview:
- Execute stage of the 5-stage RISC-V pipeline. Consumes the ID/EX pipeline register produced by the decode stage.
- Applies operand forwarding, runs the ALU and resolves branches and jumps.
- Returns PCSrcE and PCTargetE to fetch. The hazard unit uses PCSrcE to drive the decode-stage flush.
- Registers results into the EX/MEM pipeline register for the memory stage.

Parameters:
- XLEN, 32, datapath width.
- REGW, 5, register-index width.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- RD1E  in  XLEN  register-file operand 1 from ID/EX.
- RD2E  in  XLEN  register-file operand 2 from ID/EX.
- PCE  in  XLEN  PC of the instruction in execute.
- ImmExtE  in  XLEN  sign-extended immediate.
- PCPlus4E  in  XLEN  PC+4 of the instruction in execute.
- RdE  in  REGW  destination register index.
- RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE  in  1 each  control bits.
- ResultWSrcE  in  2  result select: 00 ALU, 01 memory, 10 PC+4.
- ALUControlE  in  3  ALU operation select.
- ForwardAE  in  2  operand A select from the hazard unit: 00 RD1E, 01 ResultW, 10 ALUResultM.
- ForwardBE  in  2  operand B select, same encoding.
- ResultW  in  XLEN  writeback-stage result, used for forwarding.
- PCSrcE  out  1  redirect fetch; combinational.
- PCTargetE  out  XLEN  branch/jump target; combinational.
- ALUResultM  out  XLEN  registered ALU result.
- WriteDataM  out  XLEN  registered store data.
- PCPlus4M  out  XLEN  registered PC+4.
- RdM  out  REGW  registered destination index.
- RegWriteM, MemWriteM  out  1 each  registered control.
- ResultWSrcM  out  2  registered result select.

Behaviour:
- Forwarding muxes:
  - SrcAE = RD1E, ResultW or ALUResultM, chosen by ForwardAE.
  - WriteDataE = RD2E, ResultW or ALUResultM, chosen by ForwardBE.
  - Code 11 on either select behaves as 00.
- ALU operand B: SrcBE = ALUSrcE ? ImmExtE : WriteDataE.
- ALU operations, by ALUControlE:
  - 000: add.
  - 001: sub.
  - 010: and.
  - 011: or.
  - 101: signed set-less-than; result is 1 or 0, zero-extended.
  - Codes 100, 110, 111 produce 0.
- Add and sub wrap modulo 2^XLEN. No overflow flag.
- ZeroE = (ALU result == 0).
- PCTargetE = PCE + ImmExtE, modulo 2^XLEN.
- PCSrcE = JumpE | (BranchE & ZeroE). This is combinational, with zero-cycle latency from the ID/EX inputs.
- Jump writes PCPlus4 through ResultWSrc=10. ALUResultM for a jump is whatever the ALU computed and is don't-care downstream.
- EX/MEM register, updated on every rising clk:
  - If rst=1, all M outputs load 0. RdM=0, control bits 0, ResultWSrcM=00.
  - Otherwise each M output loads its E-stage value. ALUResultM takes the ALU result and WriteDataM takes WriteDataE.
- Latency: one cycle from E inputs to M outputs. No stall input; the register captures every cycle.
- Reset behaviour:
  - Reset is sampled only at clk edges. No output is gated combinationally by rst.
  - While rst=1, PCSrcE and PCTargetE still follow their inputs. Upstream reset makes the ID/EX inputs 0, which gives PCSrcE=0.
- Reset mid-stream: the instruction present in execute at the reset edge is discarded. MemWriteM=0 and RegWriteM=0 on the next cycle guarantee no architectural side effect.
- Flushed bubble (all-zero ID/EX) produces:
  - ALU add 0+0=0, so ZeroE=1.
  - BranchE=0 and JumpE=0, so PCSrcE=0.
  - A harmless M bubble.
- Forwarding from ALUResultM uses the current registered value, i.e. the previous instruction's result. Back-to-back dependence therefore needs no extra stall.

Test Plan:
- Reset: hold rst=1 two cycles with nonzero E inputs -> all M outputs 0. Release with RdE=5, RegWriteE=1, add 3+4 -> next cycle ALUResultM=7, RdM=5, RegWriteM=1.
- Forwarding: cycle 1 add RD1E=10, RD2E=20 -> ALUResultM=30. Cycle 2 ForwardAE=10, RD1E=0, ImmExtE=1, ALUSrcE=1 -> ALUResultM=31. Then ForwardBE=01, ResultW=9, MemWriteE=1 -> WriteDataM=9.
- Branch taken: BranchE=1, sub RD1E=RD2E=0x55, PCE=0x100, ImmExtE=0xFFFFFFF0 -> PCSrcE=1, PCTargetE=0xF0 in the same cycle. Same operands with RD2E=0x56 -> PCSrcE=0.
- Jump: JumpE=1, ResultWSrcE=10, PCE=0x40, PCPlus4E=0x44, ImmExtE=0x20 -> PCSrcE=1, PCTargetE=0x60. Next cycle PCPlus4M=0x44, ResultWSrcM=10.
- ALU edges:
  - slt 0xFFFFFFFF vs 1 -> 1.
  - slt 1 vs 0xFFFFFFFF -> 0.
  - add 0xFFFFFFFF+1 -> 0 with ZeroE=1.
  - ALUControlE=111 -> 0.
  - ForwardAE=11 -> operand equals RD1E.
- Reset mid-stream: MemWriteE=1 stream, assert rst for one edge -> MemWriteM=0 that cycle. Normal capture resumes on the following edge.
